// File: rtl/serial_add_scheduler_if.sv
// serial_add_scheduler_if: request/operand/result bundle; SERIAL_SUB_EN adds per-requester subtract select
interface serial_add_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
`ifdef SERIAL_SUB_EN
  logic [NREQ-1:0]       sub;
`endif
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [WIDTH-1:0]      sum_out;
  logic                  cout_out;
`ifdef SERIAL_SUB_EN
  modport master (output req, a_in, b_in, sub, input gnt, busy, done, done_id, sum_out, cout_out);
  modport slave  (input req, a_in, b_in, sub, output gnt, busy, done, done_id, sum_out, cout_out);
`else
  modport master (output req, a_in, b_in, input gnt, busy, done, done_id, sum_out, cout_out);
  modport slave  (input req, a_in, b_in, output gnt, busy, done, done_id, sum_out, cout_out);
`endif
endinterface

// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler: round-robin shared bit-serial adder; SERIAL_SUB_EN enables a-b via inverted b and carry-in 1
module serial_add_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input logic clk,
  input logic rst,
  serial_add_scheduler_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d, ptr_q, ptr_d, did_q, did_d, win, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d, done_q, done_d, busy_q, busy_d;
  logic found, sub_w, s, c;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      logic [IDW:0] idx;
      idx = {1'b0, ptr_q} + (IDW + 1)'(k);
      idx = (idx >= (IDW + 1)'(NREQ)) ? idx - (IDW + 1)'(NREQ) : idx;
      if (bus.req[idx[IDW-1:0]]) begin
        found = 1'b1;
        win = idx[IDW-1:0];
      end
    end
  end
  assign nxt = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
`ifdef SERIAL_SUB_EN
  assign sub_w = bus.sub[win];
`else
  assign sub_w = 1'b0;
`endif
  assign s = a_q[0] ^ b_q[0] ^ carry_q;
  assign c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    carry_d = carry_q;
    cnt_d = cnt_q;
    id_d = id_q;
    ptr_d = ptr_q;
    gnt_d = '0;
    done_d = 1'b0;
    sum_d = sum_q;
    cout_d = cout_q;
    did_d = did_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = SHIFT;
        a_d = bus.a_in[win*WIDTH +: WIDTH];
        b_d = sub_w ? ~bus.b_in[win*WIDTH +: WIDTH] : bus.b_in[win*WIDTH +: WIDTH];
        carry_d = sub_w;
        cnt_d = '0;
        id_d = win;
        ptr_d = nxt;
        gnt_d[win] = 1'b1;
      end
      SHIFT: begin
        a_d = {s, a_q[WIDTH-1:1]};
        b_d = b_q >> 1;
        carry_d = c;
        cnt_d = cnt_q + 1'b1;
        // results are registered on entry to DONE so they are valid alongside done
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          done_d = 1'b1;
          sum_d = a_d;
          cout_d = c;
          did_d = id_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      carry_q <= 1'b0;
      cnt_q <= '0;
      id_q <= '0;
      ptr_q <= '0;
      gnt_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      did_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      carry_q <= carry_d;
      cnt_q <= cnt_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      busy_q <= busy_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      did_q <= did_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.done_id = did_q;
  assign bus.sum_out = sum_q;
  assign bus.cout_out = cout_q;
endmodule
